hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter: LOAD_STALL, default 2, bubble cycles inserted per load-use hazard; legal range 1..3.
REQ-002 Parameter: CNT_W, default 16, width of the performance counters.
REQ-003 Port: Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Port: Reset  in  1  asynchronous, active-high; one clock, no other clock domains.
REQ-005 Port: MemRead_EX  in  1  EX-stage instruction is a load.
REQ-006 Port: rt_address_EX  in  5  load destination register in EX.
REQ-007 Port: rs_address_ID  in  5  ID-stage source register rs.
REQ-008 Port: rt_address_ID  in  5  ID-stage source register rt.
REQ-009 Port: UsesRt_ID  in  1  ID instruction reads rt.
REQ-010 Port: Jump_ID  in  1  ID instruction is j/jal.
REQ-011 Port: JR_ID  in  1  ID instruction is jr.
REQ-012 Port: BranchTaken_EX  in  1  EX branch resolved taken.
REQ-013 Port: PCWrite  out  1  PC register load enable.
REQ-014 Port: IFID_Write  out  1  IF/ID register load enable.
REQ-015 Port: ControlMuxSig  out  1  1 = zero ID control fields into ID/EX (bubble).
REQ-016 Port: IFID_Flush  out  1  clear IF/ID contents this edge.
REQ-017 Port: IDEX_Flush  out  1  clear ID/EX contents this edge.
REQ-018 Port: Stalled  out  1  state is STALL (registered).
REQ-019 Port: StallCycles  out  CNT_W  saturating count of cycles with PCWrite=0.
REQ-020 Port: FlushCount  out  CNT_W  saturating count of cycles with IFID_Flush=1.

Function
REQ-021 load_use SHALL be MemRead_EX & (rt_address_EX!=0) & (rt_address_EX==rs_address_ID | (UsesRt_ID & rt_address_EX==rt_address_ID)).
REQ-022 FSM SHALL have two states: RUN and STALL, plus a 2-bit down-counter cnt.
REQ-023 RUN, no events: PCWrite=1, IFID_Write=1, ControlMuxSig=0, IFID_Flush=0, IDEX_Flush=0.
REQ-024 Event priority SHALL be BranchTaken_EX > load_use > (Jump_ID|JR_ID).
REQ-025 RUN & BranchTaken_EX: IFID_Flush=1, IDEX_Flush=1, PCWrite=1 in the same cycle; next state RUN.
REQ-026 RUN & load_use (no branch): PCWrite=0, IFID_Write=0, ControlMuxSig=1; if LOAD_STALL>1 next state STALL with cnt=LOAD_STALL-2, else stay RUN.
REQ-027 RUN & (Jump_ID|JR_ID), no higher event: IFID_Flush=1, PCWrite=1, IDEX_Flush=0; next state RUN.
REQ-028 STALL: PCWrite=0, IFID_Write=0, ControlMuxSig=1; cnt decrements each cycle; cnt==0 -> next RUN.
REQ-029 STALL & BranchTaken_EX: abort stall same cycle, outputs per REQ-025, next RUN, cnt=0.
REQ-030 Hazard inputs other than BranchTaken_EX SHALL be ignored in STALL.
REQ-031 Total bubble cycles per isolated load-use SHALL equal LOAD_STALL exactly.
REQ-032 StallCycles increments when PCWrite=0 and Reset=0; FlushCount increments when IFID_Flush=1; both hold at 2^CNT_W-1.

Reset
REQ-033 Reset=1 SHALL asynchronously force state=RUN, cnt=0, StallCycles=0, FlushCount=0, Stalled=0.
REQ-034 While Reset=1: PCWrite=0, IFID_Write=0, ControlMuxSig=1, IFID_Flush=0, IDEX_Flush=0.
REQ-035 Reset asserted mid-STALL SHALL abandon the stall; first cycle after release is RUN with no residual bubble.

Verification
REQ-036 MemRead_EX=1, rt_address_EX=8, rs_address_ID=8 for 1 cycle (LOAD_STALL=2) -> PCWrite=0 for exactly 2 cycles, Stalled=1 in cycle 2, StallCycles=2.
REQ-037 rt_address_EX=0 with MemRead_EX=1, rs_address_ID=0 -> no stall, PCWrite stays 1.
REQ-038 rt match with UsesRt_ID=0 -> no stall; with UsesRt_ID=1 -> stall.
REQ-039 Load-use and BranchTaken_EX same cycle -> IFID_Flush=IDEX_Flush=1, PCWrite=1, no STALL entry, FlushCount=1.
REQ-040 BranchTaken_EX in STALL cycle -> immediate flush, RUN next cycle; JR_ID=1 in RUN -> IFID_Flush=1 only.
REQ-041 Reset pulsed mid-STALL -> outputs per REQ-034 immediately, counters 0, RUN on release; counters saturate at 0xFFFF under forced stalls.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use bubble insertion, branch/jump flushing
// and saturating stall/flush performance counters.
module hazard_sequencer #(
  parameter int LOAD_STALL = 2,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       rt_address_EX,
  input  logic [4:0]       rs_address_ID,
  input  logic [4:0]       rt_address_ID,
  input  logic             UsesRt_ID,
  input  logic             Jump_ID,
  input  logic             JR_ID,
  input  logic             BranchTaken_EX,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             ControlMuxSig,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             Stalled,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  // state | meaning
  // RUN   | normal issue; the first bubble of a load-use is inserted here
  // STALL | remaining load-use bubbles, cnt counts down to the last one

  typedef enum logic {RUN, STALL} state_t;

  // The RUN cycle supplies one bubble, so STALL covers LOAD_STALL-1 cycles.
  localparam logic [1:0] CNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

  state_t     state;
  logic [1:0] cnt;
  logic       load_use;

  assign load_use = MemRead_EX && (rt_address_EX != 5'd0) &&
                    ((rt_address_EX == rs_address_ID) ||
                     (UsesRt_ID && (rt_address_EX == rt_address_ID)));

  always_comb begin
    PCWrite       = 1'b1;
    IFID_Write    = 1'b1;
    ControlMuxSig = 1'b0;
    IFID_Flush    = 1'b0;
    IDEX_Flush    = 1'b0;
    if (Reset) begin
      PCWrite       = 1'b0;
      IFID_Write    = 1'b0;
      ControlMuxSig = 1'b1;
    end else if (BranchTaken_EX) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (state == STALL || load_use) begin
      PCWrite       = 1'b0;
      IFID_Write    = 1'b0;
      ControlMuxSig = 1'b1;
    end else if (Jump_ID || JR_ID) begin
      IFID_Flush = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= RUN;
      cnt         <= 2'd0;
      Stalled     <= 1'b0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!BranchTaken_EX && load_use && (LOAD_STALL > 1)) begin
            state   <= STALL;
            cnt     <= CNT_INIT;
            Stalled <= 1'b1;
          end else begin
            cnt <= 2'd0;
          end
        end
        STALL: begin
          if (BranchTaken_EX || cnt == 2'd0) begin
            state   <= RUN;
            cnt     <= 2'd0;
            Stalled <= 1'b0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state   <= RUN;
          cnt     <= 2'd0;
          Stalled <= 1'b0;
        end
      endcase

      if (!PCWrite && StallCycles != {CNT_W{1'b1}})
        StallCycles <= StallCycles + 1'b1;
      if (IFID_Flush && FlushCount != {CNT_W{1'b1}})
        FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed pins plus randomized
// traffic compared every cycle against a bubble-budget reference model.
module tb_hazard_sequencer;
  localparam int LS   = 2;
  localparam int CW   = 10;
  localparam int MAXC = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          MemRead_EX = 1'b0;
  logic [4:0]    rt_address_EX = '0;
  logic [4:0]    rs_address_ID = '0;
  logic [4:0]    rt_address_ID = '0;
  logic          UsesRt_ID = 1'b0;
  logic          Jump_ID = 1'b0;
  logic          JR_ID = 1'b0;
  logic          BranchTaken_EX = 1'b0;
  logic          PCWrite, IFID_Write, ControlMuxSig, IFID_Flush, IDEX_Flush, Stalled;
  logic [CW-1:0] StallCycles, FlushCount;

  hazard_sequencer #(.LOAD_STALL(LS), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead_EX(MemRead_EX),
    .rt_address_EX(rt_address_EX), .rs_address_ID(rs_address_ID),
    .rt_address_ID(rt_address_ID), .UsesRt_ID(UsesRt_ID), .Jump_ID(Jump_ID),
    .JR_ID(JR_ID), .BranchTaken_EX(BranchTaken_EX), .PCWrite(PCWrite),
    .IFID_Write(IFID_Write), .ControlMuxSig(ControlMuxSig),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .Stalled(Stalled),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: number of bubbles still owed after the current cycle.
  int rem = 0;
  int msc = 0;
  int mfc = 0;

  function automatic logic model_lu();
    return MemRead_EX && rt_address_EX != 0 &&
           (rt_address_EX == rs_address_ID || (UsesRt_ID && rt_address_EX == rt_address_ID));
  endfunction

  // {PCWrite, IFID_Write, ControlMuxSig, IFID_Flush, IDEX_Flush}
  function automatic logic [4:0] model_out();
    if (Reset)                  return 5'b00100;
    else if (BranchTaken_EX)    return 5'b11011;
    else if (rem > 0)           return 5'b00100;
    else if (model_lu())        return 5'b00100;
    else if (Jump_ID || JR_ID)  return 5'b11010;
    else                        return 5'b11000;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    logic [4:0] e;
    if (Reset) begin
      rem = 0; msc = 0; mfc = 0;
    end else begin
      e = model_out();
      if (!e[4] && msc < MAXC) msc++;
      if (e[1] && mfc < MAXC) mfc++;
      if (BranchTaken_EX)  rem = 0;
      else if (rem > 0)    rem--;
      else if (model_lu()) rem = LS - 1;
    end
  end

  always @(negedge Clk) begin
    logic [4:0] e;
    e = model_out();
    chk("PCWrite", PCWrite, e[4]);
    chk("IFID_Write", IFID_Write, e[3]);
    chk("ControlMuxSig", ControlMuxSig, e[2]);
    chk("IFID_Flush", IFID_Flush, e[1]);
    chk("IDEX_Flush", IDEX_Flush, e[0]);
    chk("Stalled", Stalled, (rem > 0) ? 1 : 0);
    chk("StallCycles", StallCycles, msc);
    chk("FlushCount", FlushCount, mfc);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    MemRead_EX = 0; rt_address_EX = 0; rs_address_ID = 0; rt_address_ID = 0;
    UsesRt_ID = 0; Jump_ID = 0; JR_ID = 0; BranchTaken_EX = 0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1;
    tick(); tick();
    Reset = 0;
  endtask

  task automatic load(input logic [4:0] a);
    MemRead_EX = 1; rt_address_EX = a; rs_address_ID = a;
  endtask

  initial begin
    idle();
    tick();
    #1;
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_cms", ControlMuxSig, 1);
    chk("rst_flush", {IFID_Flush, IDEX_Flush}, 0);
    chk("rst_counters", {StallCycles, FlushCount}, 0);
    tick();
    Reset = 0;

    // isolated load-use: exactly LS bubbles
    load(5'd8);
    #1 chk("lu_c1_pcwrite", PCWrite, 0);
    tick(); idle();
    #1 chk("lu_c2_pcwrite", PCWrite, 0);
    chk("lu_c2_stalled", Stalled, 1);
    tick();
    #1 chk("lu_c3_pcwrite", PCWrite, 1);
    chk("lu_stallcycles", StallCycles, 2);

    // r0 destination never hazards
    MemRead_EX = 1; rt_address_EX = 0; rs_address_ID = 0;
    #1 chk("r0_pcwrite", PCWrite, 1);
    tick(); idle();

    // rt match only counts when the ID instruction reads rt
    MemRead_EX = 1; rt_address_EX = 5'd9; rs_address_ID = 5'd3; rt_address_ID = 5'd9;
    #1 chk("rt_nouse_pcwrite", PCWrite, 1);
    UsesRt_ID = 1;
    #1 chk("rt_use_pcwrite", PCWrite, 0);
    tick(); idle(); tick();

    // branch beats load-use
    do_reset();
    load(5'd4); BranchTaken_EX = 1;
    #1 chk("br_lu_flushes", {IFID_Flush, IDEX_Flush, PCWrite}, 3'b111);
    tick(); idle();
    #1 chk("br_lu_stalled", Stalled, 0);
    chk("br_lu_flushcount", FlushCount, 1);

    // branch aborts an in-progress stall
    load(5'd6);
    tick(); idle(); BranchTaken_EX = 1;
    #1 chk("stall_br_flushes", {IFID_Flush, IDEX_Flush, PCWrite}, 3'b111);
    tick(); idle();
    #1 chk("stall_br_run", {Stalled, PCWrite}, 2'b01);

    // jr flushes IF/ID only
    JR_ID = 1;
    #1 chk("jr_flushes", {IFID_Flush, IDEX_Flush, PCWrite}, 3'b101);
    tick(); idle();

    // reset in the middle of a stall
    load(5'd7);
    tick(); idle();
    #1 chk("mid_stall", Stalled, 1);
    #1 Reset = 1;
    #1 chk("mid_rst_outs", {PCWrite, IFID_Write, ControlMuxSig, IFID_Flush, IDEX_Flush}, 5'b00100);
    chk("mid_rst_state", {Stalled, StallCycles, FlushCount}, 0);
    tick(); Reset = 0;
    #1 chk("post_rst_run", {Stalled, PCWrite}, 2'b01);

    // saturation under continuous stalls and continuous jumps
    load(5'd5);
    repeat (MAXC + 20) tick();
    chk("stall_sat", StallCycles, MAXC);
    idle(); Jump_ID = 1;
    repeat (MAXC + 20) tick();
    chk("flush_sat", FlushCount, MAXC);
    idle();
    do_reset();

    // randomized traffic checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      tick();
      MemRead_EX     = ($urandom_range(0, 1) == 1);
      rt_address_EX  = 5'($urandom_range(0, 3));
      rs_address_ID  = 5'($urandom_range(0, 3));
      rt_address_ID  = 5'($urandom_range(0, 3));
      UsesRt_ID      = ($urandom_range(0, 1) == 1);
      Jump_ID        = ($urandom_range(0, 9) == 0);
      JR_ID          = ($urandom_range(0, 19) == 0);
      BranchTaken_EX = ($urandom_range(0, 9) == 0);
      if (Reset) Reset = 0;
      else if ($urandom_range(0, 99) == 0) begin
        #2 Reset = 1;
      end
    end
    Reset = 0;
    idle();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
